cell_window_shifter: RTL and testbench
======================================

# cell_window_shifter

Parametrised history window for the Day 3 wire-tracing datapath. It holds the last DEPTH values pushed on a tick, newest in slot 0 and oldest in slot DEPTH-1, with a valid bit per slot and an occupancy count. It also reports each value evicted from the far end and supports a rotate mode that recirculates a full window. It generalises the fixed two-slot cell rotator and feeds the segment and intersection logic, which needs N-point history rather than a single pair.

## Interface
Parameters:
- WIDTH, 32, bit width of one cell value
- DEPTH, 4, number of history slots; legal range 2..64

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  value to push
- push  in  1  shift in_data into slot 0 this cycle
- rotate  in  1  recirculate: oldest value moves to slot 0, all others shift down one
- clear  in  1  synchronous flush of all slots
- window  out  WIDTH*DEPTH  slot i on window[i*WIDTH +: WIDTH]
- valid  out  DEPTH  valid[i] set when slot i holds data
- count  out  $clog2(DEPTH+1)  number of valid slots
- full  out  1  count == DEPTH
- written  out  1  OR of valid; the "any data" flag
- evict_data  out  WIDTH  value shifted out of slot DEPTH-1 by a push
- evict_valid  out  1  one-cycle pulse qualifying evict_data

## Operation
- Command priority, highest first: rst, clear, push, rotate. Only one action takes effect per cycle.
- rst or clear: window, valid, count, evict_data and evict_valid all go to 0.
- push:
  - slot0 <= in_data; slot i <= slot i-1 for i = 1..DEPTH-1.
  - valid <= {valid[DEPTH-2:0], 1}.
  - count increments and saturates at DEPTH.
- push while full: evict_data <= old slot DEPTH-1 and evict_valid <= 1 for exactly one cycle.
- push while not full: evict_valid <= 0. evict_data holds its last value, which is don't-care.
- rotate:
  - Honoured only when full: slot0 <= old slot DEPTH-1, slot i <= slot i-1.
  - valid, count and evict are unchanged; evict_valid <= 0.
- rotate while not full: ignored entirely. No state changes and evict_valid <= 0.
- push and rotate together: push wins and rotate is dropped.
- No command: all state holds and evict_valid <= 0.
- Valid bits stay contiguous from slot 0 at all times: valid == (1<<count)-1.
- Invalid slots read 0 on window, never stale data. clear and rst zero the data, and push fills slots only from valid ones.

## Timing
- All outputs are registered. window, valid, count, full and written reflect a command on the cycle after it is sampled (1-cycle latency).
- evict_data and evict_valid update on the same edge as the push that causes them.
- full and written are derived from registered count/valid. They may be combinational from those registers but must not depend on same-cycle inputs.
- Reset mid-stream discards everything; the first push after reset lands in an empty window (count 0 to 1).
- Back-to-back pushes are sustained at one per cycle indefinitely. Saturation at full and the eviction pulse per push must hold with no bubbles.

## Structure
- Shared package aoc_day3_pkg:
  - CELL_W_DEFAULT = 32
  - WIN_DEPTH_DEFAULT = 4
  - typedef cell_t as logic [CELL_W_DEFAULT-1:0]
  - function cnt_w(depth) returning $clog2(depth+1)
- One sub-module, cell_window_slot: one WIDTH data register plus valid bit, with load and clear inputs and next-value mux select (from previous slot, in_data, or wrap from last). The top instantiates DEPTH slots in a generate loop, plus the count/evict registers and the priority decoder.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles (DEPTH=4, WIDTH=32):
  - Expect window slots 0..3 = 0x33, 0x22, 0x11, 0, with valid=4'b0111, count=3, full=0, written=1, evict_valid never set.
- Fill with 0xA, 0xB, 0xC, 0xD, then push 0xE:
  - Expect slots = 0xE, 0xD, 0xC, 0xB, count=4, and evict_valid=1 with evict_data=0xA for exactly one cycle.
- From full 0xD, 0xC, 0xB, 0xA, assert rotate for 4 cycles:
  - Expect 0xA, 0xD, 0xC, 0xB after the first, then the original order after the fourth, with evict_valid=0 throughout.
- rotate with count=2:
  - No change to any output.
- push and rotate together on a full window:
  - Behaves as push only (eviction occurs).
- clear and push together on a full window:
  - Expect all outputs 0 next cycle, with count=0 and the pushed value dropped.
- rst asserted mid-burst of pushes:
  - Outputs all 0 next cycle.
  - The next push yields valid=4'b0001 and count=1.
- Repeat the fill, eviction and rotate scenarios with DEPTH=2, WIDTH=16 and DEPTH=7, WIDTH=8 to check parameter generality.

Source files
------------

// File: rtl/aoc_day3_pkg.sv
// Shared types and sizing helpers for the Day 3 wire-tracing datapath.
// No logic and no latency; holds only declarations.
// No flow control; consumers import what they need.
package aoc_day3_pkg;

    localparam int CELL_W_DEFAULT    = 32;
    localparam int WIN_DEPTH_DEFAULT = 4;

    typedef logic [CELL_W_DEFAULT-1:0] cell_t;

    // Next-value source for one history slot when it loads.
    typedef enum logic [1:0] {
        SLOT_SEL_PREV = 2'd0,  // take the neighbour nearer slot 0
        SLOT_SEL_IN   = 2'd1,  // take the freshly pushed value
        SLOT_SEL_WRAP = 2'd2   // take the oldest slot (rotate into slot 0)
    } slot_sel_e;

    // Width of an occupancy counter that must represent 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cell_window_slot.sv
// One history slot: a data register plus its valid bit with a three-way load mux.
// Latency: loaded value appears one clk after load_i; clear/rst zero it on the same edge.
// No backpressure; the slot loads whenever load_i is high.
module cell_window_slot
    import aoc_day3_pkg::*;
#(
    parameter int WIDTH = CELL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  slot_sel_e        sel_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [WIDTH-1:0] prev_data_i,
    input  logic             prev_vld_i,
    input  logic [WIDTH-1:0] wrap_data_i,
    input  logic             wrap_vld_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    // Select the slot's next contents; hold when not loading.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (load_i) begin
            case (sel_i)
                SLOT_SEL_IN: begin
                    data_d = in_data_i;
                    vld_d  = 1'b1;
                end
                SLOT_SEL_WRAP: begin
                    data_d = wrap_data_i;
                    vld_d  = wrap_vld_i;
                end
                default: begin
                    data_d = prev_data_i;
                    vld_d  = prev_vld_i;
                end
            endcase
        end
    end

    // Slot register; reset and clear both zero the data so invalid slots read 0.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/cell_window_shifter.sv
// History window of the last DEPTH pushed cells (slot 0 newest) with eviction and rotate.
// Latency: every output is registered, one clk after the command is sampled.
// No backpressure; accepts one push per cycle indefinitely, evicting the oldest when full.
module cell_window_shifter
    import aoc_day3_pkg::*;
#(
    parameter int WIDTH = CELL_W_DEFAULT,
    parameter int DEPTH = WIN_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      push,
    input  logic                      rotate,
    input  logic                      clear,
    output logic [WIDTH*DEPTH-1:0]    window,
    output logic [DEPTH-1:0]          valid,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      written,
    output logic [WIDTH-1:0]          evict_data,
    output logic                      evict_valid
);

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] slot_dat [DEPTH];
    logic [DEPTH-1:0] slot_vld;

    logic             load;
    logic             rot_en;
    slot_sel_e        head_sel;

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] evict_data_q, evict_data_d;
    logic             evict_valid_q, evict_valid_d;

    // Status flags come only from registered state, never from this cycle's inputs.
    assign full    = (count_q == CW'(DEPTH));
    assign written = |slot_vld;

    // Priority decode: clear beats push beats rotate; rotate needs a full window.
    always_comb begin
        rot_en   = rotate && !push && full;
        load     = !clear && (push || rot_en);
        head_sel = push ? SLOT_SEL_IN : SLOT_SEL_WRAP;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            cell_window_slot #(.WIDTH(WIDTH)) u_slot (
                .clk         (clk),
                .rst         (rst),
                .clear_i     (clear),
                .load_i      (load),
                .sel_i       (head_sel),
                .in_data_i   (in_data),
                .prev_data_i (in_data),
                .prev_vld_i  (1'b1),
                .wrap_data_i (slot_dat[DEPTH-1]),
                .wrap_vld_i  (slot_vld[DEPTH-1]),
                .data_o      (slot_dat[i]),
                .vld_o       (slot_vld[i])
            );
        end else begin : g_body
            cell_window_slot #(.WIDTH(WIDTH)) u_slot (
                .clk         (clk),
                .rst         (rst),
                .clear_i     (clear),
                .load_i      (load),
                .sel_i       (SLOT_SEL_PREV),
                .in_data_i   (in_data),
                .prev_data_i (slot_dat[i-1]),
                .prev_vld_i  (slot_vld[i-1]),
                .wrap_data_i (slot_dat[DEPTH-1]),
                .wrap_vld_i  (slot_vld[DEPTH-1]),
                .data_o      (slot_dat[i]),
                .vld_o       (slot_vld[i])
            );
        end
        assign window[i*WIDTH +: WIDTH] = slot_dat[i];
    end

    // Occupancy and eviction next-state; a push into a full window evicts the oldest cell.
    always_comb begin
        count_d       = count_q;
        evict_data_d  = evict_data_q;
        evict_valid_d = 1'b0;
        if (push) begin
            if (full) begin
                evict_data_d  = slot_dat[DEPTH-1];
                evict_valid_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count and eviction registers; clear flushes them like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q       <= '0;
            evict_data_q  <= '0;
            evict_valid_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            evict_data_q  <= evict_data_d;
            evict_valid_q <= evict_valid_d;
        end
    end

    assign valid       = slot_vld;
    assign count       = count_q;
    assign evict_data  = evict_data_q;
    assign evict_valid = evict_valid_q;

endmodule

// File: tb/tb_cell_window_shifter.sv
// Directed bench for cell_window_shifter at DEPTH/WIDTH = 4/32, 2/16 and 7/8.
// Stimulus drives on the falling edge and queues the hand-computed state expected after the next rising edge.
// A monitor pops one expectation per cycle shortly after each rising edge and compares.
module tb_cell_window_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH=4, WIDTH=32
    logic         rst0, clr0, psh0, rot0;
    logic [31:0]  din0;
    logic [127:0] win0;
    logic [3:0]   vld0;
    logic [2:0]   cnt0;
    logic         full0, wr0, evv0;
    logic [31:0]  evd0;

    // Instance 1: DEPTH=2, WIDTH=16
    logic         rst1, clr1, psh1, rot1;
    logic [15:0]  din1;
    logic [31:0]  win1;
    logic [1:0]   vld1;
    logic [1:0]   cnt1;
    logic         full1, wr1, evv1;
    logic [15:0]  evd1;

    // Instance 2: DEPTH=7, WIDTH=8
    logic         rst2, clr2, psh2, rot2;
    logic [7:0]   din2;
    logic [55:0]  win2;
    logic [6:0]   vld2;
    logic [2:0]   cnt2;
    logic         full2, wr2, evv2;
    logic [7:0]   evd2;

    cell_window_shifter #(.WIDTH(32), .DEPTH(4)) u_d0 (
        .clk(clk), .rst(rst0), .in_data(din0), .push(psh0), .rotate(rot0), .clear(clr0),
        .window(win0), .valid(vld0), .count(cnt0), .full(full0), .written(wr0),
        .evict_data(evd0), .evict_valid(evv0));

    cell_window_shifter #(.WIDTH(16), .DEPTH(2)) u_d1 (
        .clk(clk), .rst(rst1), .in_data(din1), .push(psh1), .rotate(rot1), .clear(clr1),
        .window(win1), .valid(vld1), .count(cnt1), .full(full1), .written(wr1),
        .evict_data(evd1), .evict_valid(evv1));

    cell_window_shifter #(.WIDTH(8), .DEPTH(7)) u_d2 (
        .clk(clk), .rst(rst2), .in_data(din2), .push(psh2), .rotate(rot2), .clear(clr2),
        .window(win2), .valid(vld2), .count(cnt2), .full(full2), .written(wr2),
        .evict_data(evd2), .evict_valid(evv2));

    typedef struct {
        int           d;
        int           n;
        logic [127:0] w;
        logic [7:0]   v;
        logic [3:0]   c;
        logic         full;
        logic         wr;
        logic         evv;
        logic [31:0]  evd;
        logic         chk_evd;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   stepn    = 0;

    // One command cycle to instance d, with the state expected after the next rising edge.
    task automatic step(input int d, input logic r, input logic c, input logic p, input logic ro,
                        input logic [31:0] din, input logic [127:0] ew, input logic [7:0] ev,
                        input logic [3:0] ec, input logic eevv, input logic [31:0] eevd,
                        input logic chk);
        exp_t e;
        int   depth;
        @(negedge clk);
        {rst0, clr0, psh0, rot0} = '0;
        {rst1, clr1, psh1, rot1} = '0;
        {rst2, clr2, psh2, rot2} = '0;
        case (d)
            0: begin {rst0, clr0, psh0, rot0} = {r, c, p, ro}; din0 = din; end
            1: begin {rst1, clr1, psh1, rot1} = {r, c, p, ro}; din1 = din[15:0]; end
            default: begin {rst2, clr2, psh2, rot2} = {r, c, p, ro}; din2 = din[7:0]; end
        endcase
        depth     = (d == 0) ? 4 : (d == 1) ? 2 : 7;
        e.d       = d;
        e.n       = stepn;
        e.w       = ew;
        e.v       = ev;
        e.c       = ec;
        e.full    = (int'(ec) == depth);
        e.wr      = (ev != 8'h0);
        e.evv     = eevv;
        e.evd     = eevd;
        e.chk_evd = chk;
        q.push_back(e);
        stepn++;
    endtask

    // Monitor: compare one queued expectation against the addressed instance each cycle.
    always begin
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            exp_t         e;
            logic [127:0] aw;
            logic [7:0]   av;
            logic [3:0]   ac;
            logic         afull, awr, aevv;
            logic [31:0]  aevd;
            e = q.pop_front();
            case (e.d)
                0: begin aw = 128'(win0); av = 8'(vld0); ac = 4'(cnt0); afull = full0;
                         awr = wr0; aevv = evv0; aevd = 32'(evd0); end
                1: begin aw = 128'(win1); av = 8'(vld1); ac = 4'(cnt1); afull = full1;
                         awr = wr1; aevv = evv1; aevd = 32'(evd1); end
                default: begin aw = 128'(win2); av = 8'(vld2); ac = 4'(cnt2); afull = full2;
                         awr = wr2; aevv = evv2; aevd = 32'(evd2); end
            endcase
            checks++;
            if (aw !== e.w || av !== e.v || ac !== e.c || afull !== e.full || awr !== e.wr ||
                aevv !== e.evv || (e.chk_evd && aevd !== e.evd)) begin
                failures++;
                $display("FAIL step%0d dut%0d: got win=%h vld=%h cnt=%0d full=%b wr=%b evv=%b evd=%h; want win=%h vld=%h cnt=%0d full=%b wr=%b evv=%b evd=%h",
                         e.n, e.d, aw, av, ac, afull, awr, aevv, aevd,
                         e.w, e.v, e.c, e.full, e.wr, e.evv, e.evd);
            end
        end
    end

    initial begin
        {rst0, clr0, psh0, rot0, din0} = '0;
        {rst1, clr1, psh1, rot1, din1} = '0;
        {rst2, clr2, psh2, rot2, din2} = '0;

        // ---------------- DEPTH=4, WIDTH=32 ----------------
        //   d  r  c  p  ro din       window {s3,s2,s1,s0}                          vld    cnt evv evd      chk
        step(0, 1, 0, 0, 0, 32'h0,  {32'h0, 32'h0, 32'h0, 32'h0},                 8'h0, 4'd0, 0, 32'h0, 1);
        step(0, 0, 0, 1, 0, 32'h11, {32'h0, 32'h0, 32'h0, 32'h11},                8'h1, 4'd1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h22, {32'h0, 32'h0, 32'h11, 32'h22},               8'h3, 4'd2, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h33, {32'h0, 32'h11, 32'h22, 32'h33},              8'h7, 4'd3, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0,  {32'h0, 32'h11, 32'h22, 32'h33},              8'h7, 4'd3, 0, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0,  {32'h0, 32'h0, 32'h0, 32'h0},                 8'h0, 4'd0, 0, 32'h0, 1);
        step(0, 0, 0, 1, 0, 32'hA,  {32'h0, 32'h0, 32'h0, 32'hA},                 8'h1, 4'd1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hB,  {32'h0, 32'h0, 32'hA, 32'hB},                 8'h3, 4'd2, 0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h0,  {32'h0, 32'h0, 32'hA, 32'hB},                 8'h3, 4'd2, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hC,  {32'h0, 32'hA, 32'hB, 32'hC},                 8'h7, 4'd3, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hD,  {32'hA, 32'hB, 32'hC, 32'hD},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hE,  {32'hB, 32'hC, 32'hD, 32'hE},                 8'hF, 4'd4, 1, 32'hA, 1);
        step(0, 0, 0, 0, 0, 32'h0,  {32'hB, 32'hC, 32'hD, 32'hE},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0,  {32'h0, 32'h0, 32'h0, 32'h0},                 8'h0, 4'd0, 0, 32'h0, 1);
        step(0, 0, 0, 1, 0, 32'hA,  {32'h0, 32'h0, 32'h0, 32'hA},                 8'h1, 4'd1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hB,  {32'h0, 32'h0, 32'hA, 32'hB},                 8'h3, 4'd2, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hC,  {32'h0, 32'hA, 32'hB, 32'hC},                 8'h7, 4'd3, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'hD,  {32'hA, 32'hB, 32'hC, 32'hD},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h0,  {32'hB, 32'hC, 32'hD, 32'hA},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h0,  {32'hC, 32'hD, 32'hA, 32'hB},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h0,  {32'hD, 32'hA, 32'hB, 32'hC},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 0, 0, 1, 32'h0,  {32'hA, 32'hB, 32'hC, 32'hD},                 8'hF, 4'd4, 0, 32'h0, 0);
        step(0, 0, 0, 1, 1, 32'hF,  {32'hB, 32'hC, 32'hD, 32'hF},                 8'hF, 4'd4, 1, 32'hA, 1);
        step(0, 0, 1, 1, 0, 32'h99, {32'h0, 32'h0, 32'h0, 32'h0},                 8'h0, 4'd0, 0, 32'h0, 1);
        step(0, 0, 0, 1, 0, 32'h1,  {32'h0, 32'h0, 32'h0, 32'h1},                 8'h1, 4'd1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h2,  {32'h0, 32'h0, 32'h1, 32'h2},                 8'h3, 4'd2, 0, 32'h0, 0);
        step(0, 0, 0, 1, 0, 32'h3,  {32'h0, 32'h1, 32'h2, 32'h3},                 8'h7, 4'd3, 0, 32'h0, 0);
        step(0, 1, 0, 1, 0, 32'h4,  {32'h0, 32'h0, 32'h0, 32'h0},                 8'h0, 4'd0, 0, 32'h0, 1);
        step(0, 0, 0, 1, 0, 32'h5,  {32'h0, 32'h0, 32'h0, 32'h5},                 8'h1, 4'd1, 0, 32'h0, 0);

        // ---------------- DEPTH=2, WIDTH=16 ----------------
        //   d  r  c  p  ro din       window {s1,s0}           vld   cnt evv evd      chk
        step(1, 1, 0, 0, 0, 32'h0,  {16'h0, 16'h0},           8'h0, 4'd0, 0, 32'h0, 1);
        step(1, 0, 0, 1, 0, 32'hA,  {16'h0, 16'hA},           8'h1, 4'd1, 0, 32'h0, 0);
        step(1, 0, 0, 0, 1, 32'h0,  {16'h0, 16'hA},           8'h1, 4'd1, 0, 32'h0, 0);
        step(1, 0, 0, 1, 0, 32'hB,  {16'hA, 16'hB},           8'h3, 4'd2, 0, 32'h0, 0);
        step(1, 0, 0, 1, 0, 32'hC,  {16'hB, 16'hC},           8'h3, 4'd2, 1, 32'hA, 1);
        step(1, 0, 0, 0, 0, 32'h0,  {16'hB, 16'hC},           8'h3, 4'd2, 0, 32'h0, 0);
        step(1, 0, 0, 0, 1, 32'h0,  {16'hC, 16'hB},           8'h3, 4'd2, 0, 32'h0, 0);
        step(1, 0, 0, 0, 1, 32'h0,  {16'hB, 16'hC},           8'h3, 4'd2, 0, 32'h0, 0);
        step(1, 0, 0, 1, 1, 32'hD,  {16'hC, 16'hD},           8'h3, 4'd2, 1, 32'hB, 1);
        step(1, 0, 1, 1, 0, 32'hE,  {16'h0, 16'h0},           8'h0, 4'd0, 0, 32'h0, 1);
        step(1, 0, 0, 1, 0, 32'h1,  {16'h0, 16'h1},           8'h1, 4'd1, 0, 32'h0, 0);

        // ---------------- DEPTH=7, WIDTH=8 ----------------
        //   d  r  c  p  ro din      window {s6..s0}                                      vld    cnt evv evd     chk
        step(2, 1, 0, 0, 0, 32'h0, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},          8'h00, 4'd0, 0, 32'h0, 1);
        step(2, 0, 0, 1, 0, 32'h1, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1},          8'h01, 4'd1, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h2, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h2},          8'h03, 4'd2, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h3, {8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h2, 8'h3},          8'h07, 4'd3, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h4, {8'h0, 8'h0, 8'h0, 8'h1, 8'h2, 8'h3, 8'h4},          8'h0F, 4'd4, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h5, {8'h0, 8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5},          8'h1F, 4'd5, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h6, {8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6},          8'h3F, 4'd6, 0, 32'h0, 0);
        step(2, 0, 0, 0, 1, 32'h0, {8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6},          8'h3F, 4'd6, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h7, {8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7},          8'h7F, 4'd7, 0, 32'h0, 0);
        step(2, 0, 0, 1, 0, 32'h8, {8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8},          8'h7F, 4'd7, 1, 32'h1, 1);
        step(2, 0, 0, 0, 0, 32'h0, {8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8},          8'h7F, 4'd7, 0, 32'h0, 0);
        step(2, 0, 0, 0, 1, 32'h0, {8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8, 8'h2},          8'h7F, 4'd7, 0, 32'h0, 0);
        step(2, 0, 0, 0, 1, 32'h0, {8'h4, 8'h5, 8'h6, 8'h7, 8'h8, 8'h2, 8'h3},          8'h7F, 4'd7, 0, 32'h0, 0);
        step(2, 0, 0, 1, 1, 32'h9, {8'h5, 8'h6, 8'h7, 8'h8, 8'h2, 8'h3, 8'h9},          8'h7F, 4'd7, 1, 32'h4, 1);
        step(2, 0, 1, 1, 0, 32'hA, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},          8'h00, 4'd0, 0, 32'h0, 1);

        // Idle the inputs and give the monitor a bounded window to drain.
        @(negedge clk);
        {rst0, clr0, psh0, rot0} = '0;
        {rst1, clr1, psh1, rot1} = '0;
        {rst2, clr2, psh2, rot2} = '0;
        repeat (3) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d expectations still queued, want 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
